// File: rtl/mac_array_gen.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_gen
// Description : ROWS x COLS signed fixed-point multiply-accumulate array with
//               NBANK accumulator banks. Each accepted beat adds the outer
//               product in_wgt x in_act into one bank. A beat flagged in_last
//               triggers a drain of that bank, one rounded, saturated row per
//               output handshake.
//               Build option: define ACC_SAT_EN for saturating accumulation
//               (the default build wraps modulo 2^ACCW).
// Revision    : 1.0 - initial release
// ============================================================================
module mac_array_gen #(
    parameter  int ROWS  = 2,
    parameter  int COLS  = 16,
    parameter  int DW    = 16,
    parameter  int FRAC  = 9,
    parameter  int ACCW  = 40,
    parameter  int NBANK = 4,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COLS*DW-1:0]   in_act,
    input  logic [ROWS*DW-1:0]   in_wgt,
    input  logic [BW-1:0]        in_bank,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*DW-1:0]   out_data,
    output logic [RW-1:0]        out_row,
    output logic [BW-1:0]        out_bank,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic signed [ACCW:0] c_half     = (ACCW+1)'(2**(FRAC-1));
    localparam logic signed [ACCW:0] c_out_max  = (ACCW+1)'(2**(DW-1) - 1);
    localparam logic signed [ACCW:0] c_out_min  = (ACCW+1)'(-(2**(DW-1)));

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [RW-1:0]           r_row;
    logic [BW-1:0]           r_bank;
    logic                    r_live;
    logic [NBANK-1:0]        r_fresh;
    logic signed [ACCW-1:0]  r_acc [NBANK][ROWS][COLS];
    logic signed [ACCW-1:0]  w_ext [ROWS][COLS];
    logic signed [ACCW-1:0]  w_sel [COLS];
    logic                    w_accept;
    logic                    w_drain_done;
    logic                    w_pending;

    // Full-precision signed product of two DW-bit operands.
    function automatic logic signed [2*DW-1:0] mul(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b);
        logic signed [2*DW-1:0] ea;
        logic signed [2*DW-1:0] eb;
        ea = {{DW{a[DW-1]}}, a};
        eb = {{DW{b[DW-1]}}, b};
        return ea * eb;
    endfunction

    // Accumulator addition: saturating or wrapping depending on the build.
    function automatic logic signed [ACCW-1:0] acc_add(input logic signed [ACCW-1:0] a,
                                                        input logic signed [ACCW-1:0] b);
`ifdef ACC_SAT_EN
        logic signed [ACCW:0] s;
        s = (ACCW+1)'(a) + (ACCW+1)'(b);
        if (s[ACCW] != s[ACCW-1])
            return s[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        return s[ACCW-1:0];
`else
        return a + b;
`endif
    endfunction

    // Round half up by FRAC bits, then clamp into the DW-bit output range.
    function automatic logic [DW-1:0] rnd(input logic signed [ACCW-1:0] a);
        logic signed [ACCW:0] t;
        t = ((ACCW+1)'(a) + c_half) >>> FRAC;
        if (t > c_out_max)
            return c_out_max[DW-1:0];
        if (t < c_out_min)
            return c_out_min[DW-1:0];
        return t[DW-1:0];
    endfunction

    assign w_accept     = in_valid && in_ready;
    assign w_drain_done = (r_state == DRAIN) && out_ready && (r_row == RW'(ROWS-1));
    // Any bank other than the one draining still holds a partial tile.
    assign w_pending    = |(~r_fresh & ~(NBANK'(1) << r_bank));

    assign in_ready  = r_live && (r_state != DRAIN);
    assign out_valid = (r_state == DRAIN);
    assign busy      = (r_state != IDLE);
    assign out_row   = r_row;
    assign out_bank  = r_bank;

    // Sign-extended outer product of the incoming weight column and activation row.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w_ext[r][c] = ACCW'(mul(in_act[c*DW +: DW], in_wgt[r*DW +: DW]));
    end

    // Accumulator banks: load on a fresh bank, otherwise accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANK; b++)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        r_acc[b][r][c] <= '0;
        end else if (w_accept) begin
            for (int b = 0; b < NBANK; b++)
                if (b == int'(in_bank))
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            r_acc[b][r][c] <= r_fresh[b] ? w_ext[r][c]
                                                         : acc_add(r_acc[b][r][c], w_ext[r][c]);
        end
    end

    // Fresh flags: cleared by the first beat, set again once the bank has drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fresh <= '1;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (w_accept && (b == int'(in_bank)))
                    r_fresh[b] <= 1'b0;
                else if (w_drain_done && (b == int'(r_bank)))
                    r_fresh[b] <= 1'b1;
            end
        end
    end

    // Control registers: state, drain row/bank and post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_bank  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept && in_last) begin
                r_row  <= '0;
                r_bank <= in_bank;
            end else if ((r_state == DRAIN) && out_ready) begin
                r_row  <= w_drain_done ? '0 : r_row + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACC: begin
                if (w_accept)
                    w_state_nxt = in_last ? DRAIN : ACC;
            end
            DRAIN: begin
                if (w_drain_done)
                    w_state_nxt = w_pending ? ACC : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output row: select the draining bank/row per column, then round and clamp.
    always_comb begin
        out_data = '0;
        for (int c = 0; c < COLS; c++) begin
            w_sel[c] = '0;
            for (int b = 0; b < NBANK; b++)
                for (int r = 0; r < ROWS; r++)
                    if ((b == int'(r_bank)) && (r == int'(r_row)))
                        w_sel[c] = r_acc[b][r][c];
            if (r_state == DRAIN)
                out_data[c*DW +: DW] = rnd(w_sel[c]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_array_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_array_gen
// Description : Self-checking bench for mac_array_gen. A behavioural model of
//               the bank sums predicts every drained row; a compare process
//               checks each valid output row, and directed tests pin literal
//               results (rounding, saturation, stall, reset, wrap/saturate).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_array_gen;

    localparam int ROWS  = 2;
    localparam int COLS  = 16;
    localparam int DW    = 16;
    localparam int FRAC  = 9;
    localparam int ACCW  = 40;
    localparam int NBANK = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid, in_ready, in_last;
    logic [COLS*DW-1:0]  in_act;
    logic [ROWS*DW-1:0]  in_wgt;
    logic [1:0]          in_bank;
    logic                out_valid, out_ready, busy;
    logic [COLS*DW-1:0]  out_data;
    logic [0:0]          out_row;
    logic [1:0]          out_bank;

    // Small instance with a 32-bit accumulator for the long-run overflow case.
    logic                v32, ir32, last32, ov32, busy32;
    logic [2*DW-1:0]     act32, wgt32, od32;
    logic [0:0]          bank32, orow32, obank32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_array_gen #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .FRAC(FRAC), .ACCW(ACCW), .NBANK(NBANK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_wgt(in_wgt), .in_bank(in_bank), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_bank(out_bank), .busy(busy)
    );

    mac_array_gen #(.ROWS(2), .COLS(2), .DW(DW), .FRAC(FRAC), .ACCW(32), .NBANK(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32),
        .in_act(act32), .in_wgt(wgt32), .in_bank(bank32), .in_last(last32),
        .out_valid(ov32), .out_ready(1'b1), .out_data(od32),
        .out_row(orow32), .out_bank(obank32), .busy(busy32)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int                 row;
        int                 bank;
        logic [COLS*DW-1:0] data;
    } exp_t;

    longint macc [NBANK][ROWS][COLS];
    bit     mfresh [NBANK];
    exp_t   expq [$];

    function automatic longint m_add(longint a, longint b, int w);
        longint s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w-1)) - 1;
        lo = -(64'sd1 <<< (w-1));
`ifdef ACC_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
`else
        if (hi < lo) return 0;
        return (s <<< (64-w)) >>> (64-w);
`endif
    endfunction

    function automatic logic [DW-1:0] m_round(longint a);
        longint y;
        y = (a + (64'sd1 <<< (FRAC-1))) >>> FRAC;
        if (y > 2**(DW-1) - 1) y = 2**(DW-1) - 1;
        if (y < -(2**(DW-1)))  y = -(2**(DW-1));
        return y[DW-1:0];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NBANK; b++) begin
            mfresh[b] = 1'b1;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    macc[b][r][c] = 0;
        end
        expq.delete();
    endtask

    task automatic model_accept(int bank, bit last);
        logic signed [DW-1:0] a, w;
        longint p;
        exp_t e;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                a = in_act[c*DW +: DW];
                w = in_wgt[r*DW +: DW];
                p = longint'(a) * longint'(w);
                macc[bank][r][c] = mfresh[bank] ? p : m_add(macc[bank][r][c], p, ACCW);
            end
        mfresh[bank] = 1'b0;
        if (last) begin
            for (int r = 0; r < ROWS; r++) begin
                e.row  = r;
                e.bank = bank;
                e.data = '0;
                for (int c = 0; c < COLS; c++)
                    e.data[c*DW +: DW] = m_round(macc[bank][r][c]);
                expq.push_back(e);
            end
            mfresh[bank] = 1'b1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_act(logic [DW-1:0] v);
        for (int c = 0; c < COLS; c++) in_act[c*DW +: DW] = v;
    endtask

    task automatic set_wgt(logic [DW-1:0] v);
        for (int r = 0; r < ROWS; r++) in_wgt[r*DW +: DW] = v;
    endtask

    // Present one beat (called at a falling edge); returns at the falling edge after accept.
    task automatic beat(int bank, bit last);
        int t;
        in_bank  = 2'(bank);
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("beat_accept_timeout", {63'd0, in_ready}, 64'd1);
        if (in_ready) model_accept(bank, last);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_row", 64'd1, 64'd0);
            end else begin
                chk("row_data", {32'd0, out_data[31:0]} ^ 64'(out_data != expq[0].data),
                    {32'd0, expq[0].data[31:0]});
                chk("row_full", 64'(out_data == expq[0].data), 64'd1);
                chk("row_index", 64'(out_row), 64'(expq[0].row));
                chk("row_bank", 64'(out_bank), 64'(expq[0].bank));
                chk("ready_low_in_drain", 64'(in_ready), 64'd0);
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        longint s39;
        logic [DW-1:0] e39;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bank = '0;
        in_act = '0; in_wgt = '0; out_ready = 1'b1;
        v32 = 1'b0; last32 = 1'b0; act32 = '0; wgt32 = '0; bank32 = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data != '0), 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_out_bank", 64'(out_bank), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(in_ready), 64'd1);

        // three beats of 512*512 into bank 0
        set_act(16'd512); set_wgt(16'd512);
        beat(0, 0); beat(0, 0); beat(0, 1);
        chk("t34_valid", 64'(out_valid), 64'd1);
        chk("t34_row0", 64'(out_row), 64'd0);
        chk("t34_r0_data", 64'(out_data[5*DW +: DW]), 64'd1536);
        @(negedge clk);
        chk("t34_valid_r1", 64'(out_valid), 64'd1);
        chk("t34_row1", 64'(out_row), 64'd1);
        chk("t34_r1_data", 64'(out_data[15*DW +: DW]), 64'd1536);
        @(negedge clk);
        chk("t34_done_valid", 64'(out_valid), 64'd0);
        chk("t34_ready_back", 64'(in_ready), 64'd1);
        chk("t34_idle", 64'(busy), 64'd0);

        // positive and negative saturation
        set_act(16'h7FFF); set_wgt(16'h7FFF);
        beat(1, 1);
        chk("t35_pos_sat", 64'(out_data[0 +: DW]), 64'h7FFF);
        repeat (2) @(negedge clk);
        set_act(16'h8000);
        beat(1, 1);
        chk("t35_neg_sat", 64'(out_data[3*DW +: DW]), 64'h8000);
        repeat (2) @(negedge clk);

        // rounding boundaries
        set_act(16'd0);
        in_act[0 +: DW]  = 16'd1;
        in_act[DW +: DW] = 16'hFFFF;
        in_wgt[0 +: DW]  = 16'd256;
        in_wgt[DW +: DW] = 16'd255;
        beat(2, 1);
        chk("t36_1x256", 64'(out_data[0 +: DW]), 64'd1);
        chk("t36_m1x256", 64'(out_data[DW +: DW]), 64'd0);
        @(negedge clk);
        chk("t36_1x255", 64'(out_data[0 +: DW]), 64'd0);
        @(negedge clk);

        // interleaved banks with an output stall
        set_act(16'd512); set_wgt(16'd512);   beat(0, 0);
        set_wgt(16'd1024);                    beat(2, 0);
        set_wgt(16'd512);                     beat(0, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t37_stall_ready", 64'(in_ready), 64'd0);
            chk("t37_stall_row", 64'(out_row), 64'd0);
            chk("t37_stall_data", 64'(out_data[7*DW +: DW]), 64'd1024);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t37_acc_busy", 64'(busy), 64'd1);
        chk("t37_acc_ready", 64'(in_ready), 64'd1);
        set_act(16'd0);
        beat(2, 1);
        chk("t37_bank2", 64'(out_data[9*DW +: DW]), 64'd1024);
        chk("t37_bank2_id", 64'(out_bank), 64'd2);
        repeat (2) @(negedge clk);

        // mixed column/row pattern checked by the model
        for (int c = 0; c < COLS; c++) in_act[c*DW +: DW] = 16'(c*37 - 300);
        in_wgt[0 +: DW] = 16'd100; in_wgt[DW +: DW] = 16'hFF38;
        beat(1, 0);
        for (int c = 0; c < COLS; c++) in_act[c*DW +: DW] = 16'(1000 - c*151);
        in_wgt[0 +: DW] = 16'hFC00; in_wgt[DW +: DW] = 16'd777;
        beat(1, 1);
        repeat (2) @(negedge clk);

        // reset in the middle of a drain
        set_act(16'd512); set_wgt(16'd512);
        beat(3, 1);
        @(negedge clk);
        chk("t38_row1_before_rst", 64'(out_row), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t38_valid_in_rst", 64'(out_valid), 64'd0);
        chk("t38_busy_in_rst", 64'(busy), 64'd0);
        chk("t38_ready_in_rst", 64'(in_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(3, 1);
        chk("t38_fresh_sum", 64'(out_data[0 +: DW]), 64'd512);
        repeat (2) @(negedge clk);

        // 2^14 beats of 0x7FFF*0x7FFF into a 32-bit accumulator
        s39 = 0;
        for (int i = 0; i < 16384; i++) s39 = m_add(s39, 64'sd1073676289, 32);
        e39 = m_round(s39);
`ifdef ACC_SAT_EN
        chk("t39_model_pin", 64'(e39), 64'h7FFF);
`else
        chk("t39_model_pin", 64'(e39), 64'h8000);
`endif
        chk("t39_ready", 64'(ir32), 64'd1);
        act32 = {2{16'h7FFF}}; wgt32 = {2{16'h7FFF}};
        v32 = 1'b1;
        repeat (16383) @(negedge clk);
        last32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0; last32 = 1'b0;
        chk("t39_valid", 64'(ov32), 64'd1);
        chk("t39_c0", 64'(od32[0 +: DW]), 64'(e39));
        chk("t39_c1", 64'(od32[DW +: DW]), 64'(e39));
        repeat (3) @(negedge clk);
        chk("t39_done", 64'(busy32), 64'd0);

        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_array_gen.md
MAC_ARRAY_GEN -- requirements
Module: mac_array_gen

Interface
REQ-001 SHALL have parameter ROWS, default 2, the number of weight rows (accumulator rows).
REQ-002 SHALL have parameter COLS, default 16, the number of activation columns.
REQ-003 SHALL have parameter DW, default 16, the signed fixed-point operand and result width.
REQ-004 SHALL have parameter FRAC, default 9, the number of fractional bits per operand.
REQ-005 SHALL have parameter ACCW, default 40, the signed accumulator width (ACCW >= 2*DW).
REQ-006 SHALL have parameter NBANK, default 4, the number of accumulator banks (BW = clog2(NBANK), minimum 1).
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  array can accept a beat.
REQ-011 in_act  input  COLS*DW  activation row; column c = bits [c*DW +: DW].
REQ-012 in_wgt  input  ROWS*DW  weight column; row r = bits [r*DW +: DW].
REQ-013 in_bank  input  BW  target accumulator bank for this beat.
REQ-014 in_last  input  1  final beat of the tile for in_bank; triggers drain.
REQ-015 out_valid  output  1  output row valid.
REQ-016 out_ready  input  1  downstream accepts output row.
REQ-017 out_data  output  COLS*DW  rounded, saturated row; column c = bits [c*DW +: DW].
REQ-018 out_row  output  clog2(ROWS)  index of the row in out_data.
REQ-019 out_bank  output  BW  bank being drained.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, ACC, DRAIN; IDLE->ACC on an accepted beat without in_last; IDLE or ACC->DRAIN on an accepted beat with in_last; DRAIN->ACC, or DRAIN->IDLE when no bank holds data, after the handshake of row ROWS-1.
REQ-022 in_ready SHALL be 1 in IDLE and ACC and 0 in DRAIN; a beat is accepted when in_valid && in_ready.
REQ-023 On accept, each cell (r,c) of bank in_bank SHALL compute signed in_act[c]*in_wgt[r] (2*DW bits), sign-extend it to ACCW, and load it when the bank's fresh flag is set, else add it; the result is visible the next cycle.
REQ-024 Each bank SHALL keep a fresh flag: set at reset, cleared by the first accepted beat, set again when that bank's drain completes.
REQ-025 Without ACC_SAT_EN, accumulator addition SHALL wrap modulo 2^ACCW.
REQ-026 An accepted in_last beat SHALL be included in the drained result; out_valid SHALL rise on the cycle after that accept, with out_row=0 and out_bank equal to the drained bank.
REQ-027 Output rounding SHALL be y = (acc + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift), then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-028 Rows SHALL be emitted in order 0..ROWS-1, one per out_valid && out_ready handshake; out_data, out_row and out_bank SHALL stay stable while out_valid && !out_ready.
REQ-029 With out_ready held high, the drain SHALL take exactly ROWS cycles, and in_ready SHALL reassert on the cycle after the final handshake.
REQ-030 Banks other than the draining bank SHALL retain their contents and fresh flags across a drain.

Reset
REQ-031 While rst_n is low: state=IDLE, all accumulators=0, all fresh flags=1, out_valid=0, out_data=0, out_row=0, out_bank=0, busy=0, in_ready=0.
REQ-032 After release, in_ready SHALL be 1 from the first clock edge; reset asserted mid-ACC or mid-DRAIN SHALL discard all partial results and pending rows.

Configuration
REQ-033 With macro ACC_SAT_EN defined, accumulator addition SHALL saturate to [-2^(ACCW-1), 2^(ACCW-1)-1]; without it, addition SHALL wrap (REQ-025); the interface is identical in both builds.

Verification
REQ-034 Default parameters, bank 0, three beats of act=all 512 and wgt=all 512, last on the third beat -> rows 0 and 1 each output 1536 in every column, on consecutive cycles with out_ready=1.
REQ-035 Single beat of act=0x7FFF and wgt=0x7FFF, and a separate beat of act=0x8000 and wgt=0x7FFF -> outputs 0x7FFF and 0x8000 respectively.
REQ-036 act=1 with wgt=256 -> output 1; act=1 with wgt=255 -> output 0; act=-1 with wgt=256 -> output 0 (rounding boundaries).
REQ-037 Interleave bank 0 (act=512, wgt=512) and bank 2 (act=512, wgt=1024); last on bank 0, hold out_ready=0 for 5 cycles -> row 0 of bank 0 stays stable and in_ready=0; then last on bank 2 -> output 1024.
REQ-038 Assert rst_n low during DRAIN after row 0 -> out_valid=0 immediately; next tile on the same bank outputs only its own sum.
REQ-039 ACCW=32 with 2^14 beats of 0x7FFF*0x7FFF -> with ACC_SAT_EN the output is 0x7FFF; without ACC_SAT_EN the output matches the wrapped-sum reference model.
